// File: rtl/color_blend_unit.sv
// color_blend_unit: per-fragment alpha-blend and masked write of the RGBA8888 colour buffer.
// Define CBLEND_STATS_EN to build the written/killed fragment counters; otherwise both outputs read 0.
module color_blend_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int COORD_WIDTH = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   busy_o,
    input  logic                   frag_valid_i,
    output logic                   frag_ready_o,
    input  logic [COORD_WIDTH-1:0] frag_x_i,
    input  logic [COORD_WIDTH-1:0] frag_y_i,
    input  logic [31:0]            frag_color_i,
    input  logic                   frag_test_pass_i,
    input  logic                   blend_enable_i,
    input  logic [1:0]             src_factor_i,
    input  logic [1:0]             dst_factor_i,
    input  logic [3:0]             color_wmask_i,
    input  logic [ADDR_WIDTH-1:0]  fb_base_i,
    input  logic [COORD_WIDTH-1:0] fb_pitch_i,
    output logic [ADDR_WIDTH-1:0]  cbuf_addr_o,
    output logic                   cbuf_read_o,
    input  logic [31:0]            cbuf_rdata_i,
    output logic                   cbuf_write_o,
    output logic [31:0]            cbuf_wdata_o,
    output logic [3:0]             cbuf_be_o,
    input  logic                   cbuf_ready_i,
    output logic [CNT_WIDTH-1:0]   written_cnt_o,
    output logic [CNT_WIDTH-1:0]   killed_cnt_o
);
    localparam int PW = 2 * COORD_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, READ, BLEND, WRITE} state_t;

    state_t                  state, next;
    logic [31:0]             src, dst, wdata, blended;
    logic [1:0]              sf, df;
    logic [3:0]              be;
    logic [ADDR_WIDTH-1:0]   addr, addr_calc;
    logic [PW-1:0]           pix;
    logic                    accept, kill, take;

    function automatic logic [7:0] norm(input logic [15:0] p);
        logic [16:0] t;
        t = {1'b0, p} + 17'd128;
        return 8'((t + (t >> 8)) >> 8);
    endfunction

    function automatic logic [7:0] factor(input logic [1:0] sel, input logic [7:0] a);
        return sel == 2'd0 ? 8'd0 : sel == 2'd1 ? 8'd255 : sel == 2'd2 ? a : 8'd255 - a;
    endfunction

    function automatic logic [7:0] blend_ch(input logic [7:0] cs, cd, fs, fd);
        logic [8:0] sum;
        sum = {1'b0, norm(16'(cs) * 16'(fs))} + {1'b0, norm(16'(cd) * 16'(fd))};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign accept    = frag_valid_i & frag_ready_o;
    assign kill      = ~frag_test_pass_i | (color_wmask_i == 4'd0);
    assign take      = accept & ~kill;
    assign pix       = PW'(frag_y_i) * PW'(fb_pitch_i) + PW'(frag_x_i);
    assign addr_calc = fb_base_i + ADDR_WIDTH'({pix, 2'b00});

    for (genvar c = 0; c < 4; c++) begin : g_ch
        assign blended[8*c +: 8] = blend_ch(src[8*c +: 8], dst[8*c +: 8],
                                            factor(sf, src[31:24]), factor(df, src[31:24]));
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        unique case (state)
            IDLE:  next = take ? (blend_enable_i ? READ : WRITE) : IDLE;
            READ:  next = cbuf_ready_i ? BLEND : READ;
            BLEND: next = WRITE;
            WRITE: next = cbuf_ready_i ? IDLE : WRITE;
        endcase
    end

    always_comb begin
        frag_ready_o = (state == IDLE) & ~rst_i;
        busy_o       = state != IDLE;
        cbuf_read_o  = state == READ;
        cbuf_write_o = state == WRITE;
    end

    // wdata carries src straight through for overwrite; BLEND replaces it with the blended value
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            src   <= '0;
            dst   <= '0;
            wdata <= '0;
            sf    <= '0;
            df    <= '0;
            be    <= '0;
            addr  <= '0;
        end else begin
            if (take) begin
                src   <= frag_color_i;
                wdata <= frag_color_i;
                sf    <= src_factor_i;
                df    <= dst_factor_i;
                be    <= color_wmask_i;
                addr  <= addr_calc;
            end
            if (state == READ && cbuf_ready_i) dst <= cbuf_rdata_i;
            if (state == BLEND) wdata <= blended;
        end

    assign cbuf_addr_o  = addr;
    assign cbuf_wdata_o = wdata;
    assign cbuf_be_o    = be;

`ifdef CBLEND_STATS_EN
    logic [CNT_WIDTH-1:0] written, killed;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            written <= '0;
            killed  <= '0;
        end else begin
            if (state == WRITE && cbuf_ready_i) written <= written + 1'b1;
            if (accept && kill) killed <= killed + 1'b1;
        end

    assign written_cnt_o = written;
    assign killed_cnt_o  = killed;
`else
    assign written_cnt_o = '0;
    assign killed_cnt_o  = '0;
`endif
endmodule
